// File: rtl/hud_digit_renderer.sv
// HUD digit renderer: per-frame binary->BCD of lives/money (26-cycle conversion), 2-cycle pixel pipeline.
// No backpressure: frame_start is dropped while busy, and the pixel path runs every cycle.
module hud_digit_renderer #(
  parameter logic [9:0] LIVES_X = 10'd16,
  parameter logic [9:0] LIVES_Y = 10'd8,
  parameter logic [9:0] MONEY_X = 10'd16,
  parameter logic [9:0] MONEY_Y = 10'd32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  lives_in,
  input  logic [13:0] money_in,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        hud_pixel,
  output logic        hud_is_money,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, CONV_LIVES, CONV_MONEY, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [9:0]  lives_sr;
  logic [13:0] money_sr;
  logic [15:0] bcd, dab, bcd_nxt;
  logic        shift_in;
  logic [11:0] lives_bcd, lives_dig;
  logic [15:0] money_dig;
  logic [9:0]  lives_sat;
  logic [13:0] money_sat;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = LOAD;
      end
      LOAD:       state_nxt = CONV_LIVES;
      CONV_LIVES: if (cnt == 4'd9)  state_nxt = CONV_MONEY;
      CONV_MONEY: if (cnt == 4'd13) state_nxt = COMMIT;
      COMMIT: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // One double-dabble step shared by both conversions; only the serial input bit differs.
  always_comb begin
    dab = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) dab[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    shift_in = (state == CONV_MONEY) ? money_sr[13] : lives_sr[9];
    bcd_nxt  = (dab << 1) | {15'd0, shift_in};
  end

  assign lives_sat = (lives_in > 10'd999)   ? 10'd999   : lives_in;
  assign money_sat = (money_in > 14'd9999)  ? 14'd9999  : money_in;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= 4'd0;
      lives_sr  <= 10'd0;
      money_sr  <= 14'd0;
      bcd       <= 16'd0;
      lives_bcd <= 12'd0;
      lives_dig <= 12'd0;
      money_dig <= 16'd0;
    end else begin
      case (state)
        LOAD: begin
          lives_sr <= lives_sat;
          money_sr <= money_sat;
          bcd      <= 16'd0;
          cnt      <= 4'd0;
        end
        CONV_LIVES: begin
          lives_sr <= lives_sr << 1;
          if (cnt == 4'd9) begin
            lives_bcd <= bcd_nxt[11:0];
            bcd       <= 16'd0;
            cnt       <= 4'd0;
          end else begin
            bcd <= bcd_nxt;
            cnt <= cnt + 4'd1;
          end
        end
        CONV_MONEY: begin
          money_sr <= money_sr << 1;
          bcd      <= bcd_nxt;
          cnt      <= cnt + 4'd1;
        end
        COMMIT: begin
          lives_dig <= lives_bcd;
          money_dig <= bcd;
        end
        default: ;
      endcase
    end
  end

  logic [9:0] dx_l, dy_l, dx_m, dy_m;
  logic       hit_l, hit_m, drawn;
  logic [3:0] digit_val, row;
  logic [1:0] idx;
  logic [2:0] col;
  logic [2:0] col_q;
  logic       hit_q, field_q;

  // The >= guards make the wrapped subtraction safe; the range checks use the offset's upper bits.
  always_comb begin
    dx_l  = DrawX - LIVES_X;
    dy_l  = DrawY - LIVES_Y;
    dx_m  = DrawX - MONEY_X;
    dy_m  = DrawY - MONEY_Y;
    hit_l = (DrawX >= LIVES_X) && (dx_l[9:3] < 7'd3) &&
            (DrawY >= LIVES_Y) && (dy_l[9:4] == 6'd0);
    hit_m = (DrawX >= MONEY_X) && (dx_m[9:3] < 7'd4) &&
            (DrawY >= MONEY_Y) && (dy_m[9:4] == 6'd0);
    digit_val = 4'd0;
    drawn     = 1'b0;
    idx       = dx_m[4:3];
    row       = dy_m[3:0];
    col       = dx_m[2:0];
    if (hit_l) begin
      idx = dx_l[4:3];
      row = dy_l[3:0];
      col = dx_l[2:0];
      case (idx)
        2'd0: begin digit_val = lives_dig[11:8]; drawn = (lives_dig[11:8] != 4'd0); end
        2'd1: begin digit_val = lives_dig[7:4];  drawn = (lives_dig[11:4] != 8'd0); end
        default: begin digit_val = lives_dig[3:0]; drawn = 1'b1; end
      endcase
    end else if (hit_m) begin
      case (idx)
        2'd0: begin digit_val = money_dig[15:12]; drawn = (money_dig[15:12] != 4'd0); end
        2'd1: begin digit_val = money_dig[11:8];  drawn = (money_dig[15:8] != 8'd0); end
        2'd2: begin digit_val = money_dig[7:4];   drawn = (money_dig[15:4] != 12'd0); end
        default: begin digit_val = money_dig[3:0]; drawn = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr     <= 11'd0;
      col_q        <= 3'd0;
      hit_q        <= 1'b0;
      field_q      <= 1'b0;
      hud_pixel    <= 1'b0;
      hud_is_money <= 1'b0;
    end else begin
      rom_addr     <= (hit_l | hit_m) ? {3'b000, digit_val, row} : 11'd0;
      col_q        <= col;
      hit_q        <= (hit_l | hit_m) & drawn;
      field_q      <= ~hit_l & hit_m;
      hud_pixel    <= hit_q & rom_data[3'd7 - col_q];
      hud_is_money <= field_q;
    end
  end

endmodule

// File: tb/tb_hud_digit_renderer.sv
// Bench for hud_digit_renderer: vector table, timing sequences, randomized frames/pixels vs. arithmetic model.
module tb_hud_digit_renderer;

  logic        Clk, Reset, frame_start;
  logic [9:0]  lives_in;
  logic [13:0] money_in;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        hud_pixel, hud_is_money, busy, done;

  logic [7:0] rom [2048];
  assign rom_data = rom[rom_addr];

  hud_digit_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .lives_in(lives_in), .money_in(money_in),
    .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hud_pixel(hud_pixel), .hud_is_money(hud_is_money),
    .busy(busy), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  int disp_lv = 0;
  int disp_mn = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // Reference: what a viewer should see at (x,y) given the displayed decimal values.
  function automatic void ref_pix(input int x, input int y, input int lv, input int mn,
                                  output int addr, output int pix, output int fld);
    int idx, p, d, col;
    bit hit, drawn;
    hit = 0; drawn = 0; addr = 0; pix = 0; fld = 0; col = 0;
    if (x >= 16 && x < 16 + 24 && y >= 8 && y < 8 + 16) begin
      idx = (x - 16) / 8;
      p = pow10(2 - idx);
      d = (lv / p) % 10;
      drawn = (idx == 2) || (lv >= p);
      addr = d * 16 + (y - 8);
      col = (x - 16) % 8;
      hit = 1;
    end else if (x >= 16 && x < 16 + 32 && y >= 32 && y < 32 + 16) begin
      idx = (x - 16) / 8;
      p = pow10(3 - idx);
      d = (mn / p) % 10;
      drawn = (idx == 3) || (mn >= p);
      addr = d * 16 + (y - 32);
      col = (x - 16) % 8;
      hit = 1;
      fld = 1;
    end
    if (hit && drawn) pix = int'(rom[addr][7 - col]);
  endfunction

  task automatic check_pix(input int x, input int y, input string tag);
    int ea, ep, ef;
    ref_pix(x, y, disp_lv, disp_mn, ea, ep, ef);
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    chk({tag, " rom_addr"}, int'(rom_addr), ea);
    tick();
    chk({tag, " hud_pixel"}, int'(hud_pixel), ep);
    chk({tag, " hud_is_money"}, int'(hud_is_money), ef);
  endtask

  task automatic run_frame(input int lv, input int mn, input bit noise, input bit spur);
    int busy_cnt, done_cnt, done_at, busy_first;
    busy_cnt = 0; done_cnt = 0; done_at = -1; busy_first = -1;
    lives_in = lv[9:0];
    money_in = mn[13:0];
    frame_start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      frame_start = spur && (n == 5);
      if (noise && n >= 2) begin
        lives_in = 10'($urandom);
        money_in = 14'($urandom);
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = n;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    frame_start = 1'b0;
    chk("busy start cycle", busy_first, 1);
    chk("busy cycle count", busy_cnt, 26);
    chk("done cycle", done_at, 26);
    chk("done pulse count", done_cnt, 1);
  endtask

  task automatic check_fields(input string tag);
    for (int i = 0; i < 3; i++) check_pix(16 + 8 * i + (i * 3) % 8, 8 + 2 + i * 4, {tag, " lives"});
    for (int i = 0; i < 4; i++) check_pix(16 + 8 * i + (i * 5) % 8, 32 + 1 + i * 3, {tag, " money"});
  endtask

  task automatic rand_sweep(input int n);
    int xs[$], ys[$];
    int ea, ep, ef;
    for (int c = 0; c <= n; c++) begin
      if (c < n) begin
        xs.push_back($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 63));
        ys.push_back($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 55));
        DrawX = 10'(xs[c]);
        DrawY = 10'(ys[c]);
      end
      tick();
      if (c < n) begin
        ref_pix(xs[c], ys[c], disp_lv, disp_mn, ea, ep, ef);
        chk("rand rom_addr", int'(rom_addr), ea);
      end
      if (c >= 1) begin
        ref_pix(xs[c-1], ys[c-1], disp_lv, disp_mn, ea, ep, ef);
        chk("rand hud_pixel", int'(hud_pixel), ep);
        chk("rand hud_is_money", int'(hud_is_money), ef);
      end
    end
  endtask

  typedef struct {
    int lv;
    int mn;
    bit spur;
    int exp_lv;
    int exp_mn;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lv, mn, done_seen;

    vt[0] = '{42,   1234,  1'b1, 42,  1234};
    vt[1] = '{1023, 16383, 1'b0, 999, 9999};
    vt[2] = '{0,    0,     1'b0, 0,   0};
    vt[3] = '{999,  9999,  1'b0, 999, 9999};
    vt[4] = '{1000, 10000, 1'b0, 999, 9999};
    vt[5] = '{100,  1005,  1'b1, 100, 1005};
    vt[6] = '{5,    90,    1'b0, 5,   90};
    vt[7] = '{7,    0,     1'b0, 7,   0};

    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[114] = 8'h80;
    rom[2]   = 8'hFF;

    Reset = 1'b1;
    frame_start = 1'b0;
    lives_in = '0;
    money_in = '0;
    DrawX = '0;
    DrawY = '0;
    tick();
    tick();
    chk("reset rom_addr", int'(rom_addr), 0);
    chk("reset hud_pixel", int'(hud_pixel), 0);
    chk("reset hud_is_money", int'(hud_is_money), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    Reset = 1'b0;

    // Reset digits render as "0": lives field digit 2, row 2.
    DrawX = 10'd32;
    DrawY = 10'd10;
    tick();
    chk("reset digit rom_addr", int'(rom_addr), 2);
    tick();
    chk("reset digit hud_pixel", int'(hud_pixel), 1);
    check_fields("reset");

    for (int v = 0; v < 8; v++) begin
      run_frame(vt[v].lv, vt[v].mn, 1'b0, vt[v].spur);
      disp_lv = vt[v].exp_lv;
      disp_mn = vt[v].exp_mn;
      check_fields($sformatf("vec%0d", v));
    end

    // lives = 7 is displayed now.
    DrawX = 10'd32;
    DrawY = 10'd10;
    tick();
    chk("seven rom_addr", int'(rom_addr), 114);
    DrawX = 10'd39;
    tick();
    chk("seven hud_pixel", int'(hud_pixel), 1);
    chk("seven hud_is_money", int'(hud_is_money), 0);
    DrawX = 10'd16;
    tick();
    chk("seven col7 hud_pixel", int'(hud_pixel), 0);
    tick();
    chk("blank lead rom_addr", int'(rom_addr), 2);
    chk("blank lead hud_pixel", int'(hud_pixel), 0);

    for (int f = 0; f < 6; f++) begin
      lv = $urandom_range(0, 1023);
      mn = $urandom_range(0, 16383);
      run_frame(lv, mn, 1'b1, f[0]);
      disp_lv = (lv > 999) ? 999 : lv;
      disp_mn = (mn > 9999) ? 9999 : mn;
      rand_sweep(120);
    end

    // Reset in the middle of a conversion.
    run_frame(123, 4567, 1'b0, 1'b0);
    disp_lv = 123;
    disp_mn = 4567;
    check_pix(16, 8, "pre-reset lives");
    lives_in = 10'd500;
    money_in = 14'd8888;
    frame_start = 1'b1;
    done_seen = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      frame_start = 1'b0;
      if (done) done_seen++;
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("midreset no done/busy", done_seen, 0);
    disp_lv = 0;
    disp_mn = 0;
    check_pix(32, 10, "midreset lives");
    check_pix(40, 34, "midreset money");
    check_pix(16, 10, "midreset blank");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hud_digit_renderer.md
# hud_digit_renderer

Converts the live game counters (lives, money) into decimal glyphs on the VGA overlay by sequencing the shared 160-entry digit font ROM. Once per frame it converts both binary values to BCD with one shared shift-add-3 engine and commits the digits atomically. During active video it turns each (DrawX, DrawY) into a font ROM address and a registered 1-bit HUD pixel. It sits between the game-state logic and the colour mapper.

## Interface
- LIVES_X, 10'd16: left pixel column of the 3-digit lives field.
- LIVES_Y, 10'd8: top pixel row of the lives field.
- MONEY_X, 10'd16: left pixel column of the 4-digit money field.
- MONEY_Y, 10'd32: top pixel row of the money field.
- Clk  in  1  system/pixel clock, one pixel per cycle.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- lives_in  in  10  binary lives count.
- money_in  in  14  binary money count.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- rom_addr  out  11  font ROM address = digit*16 + glyph row; registered.
- rom_data  in  8  font ROM output (combinational read of rom_addr); bit 7 = leftmost pixel.
- hud_pixel  out  1  glyph foreground at the pixel presented 2 cycles earlier.
- hud_is_money  out  1  qualifies hud_pixel: 1 = money field, 0 = lives field.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new digits are committed.

## Operation
- FSM states: IDLE, LOAD, CONV_LIVES, CONV_MONEY, COMMIT.
- IDLE: a frame_start pulse moves the FSM to LOAD. Pulses in any other state are ignored, not queued.
- LOAD (1 cycle):
  - Snapshot lives_in and money_in.
  - Saturate lives to 999 and money to 9999.
  - Clear the BCD accumulators.
- CONV_LIVES (10 cycles), then CONV_MONEY (14 cycles), one double-dabble iteration per cycle:
  - Each cycle, add 3 to every BCD nibble ≥5, then shift left 1 bit, bringing in the snapshot MSB.
- COMMIT (1 cycle):
  - Copy both BCD results into the display digit registers.
  - Pulse done and return to IDLE.
  - The display registers change only here, so no frame ever shows half-updated digits.
- busy = 1 in LOAD, CONV_LIVES, CONV_MONEY and COMMIT.
- Leading-zero blanking: leading zero digits are not drawn. The least-significant digit is always drawn, so a value of 0 shows "0".
- Pixel path:
  - Field hit test: X ≤ DrawX < X+8·N and Y ≤ DrawY < Y+16, with N = 3 (lives) or 4 (money).
  - Field offsets: dx = DrawX − X, dy = DrawY − Y.
  - Within a field: digit index = dx[9:3] (0 = most significant), glyph row = dy[3:0], column = dx[2:0].
  - If both fields hit, lives wins.
- Stage 1 (registered):
  - rom_addr = {3'b0, digit_value, row}.
  - Also register column, field select, and hit qualified by blanking.
  - On a miss, rom_addr = 0.
- Stage 2 (registered):
  - hud_pixel = hit_q & rom_data[7 − col_q].
  - hud_is_money = field_q.

## Timing
- Reset values:
  - rom_addr = 0, hud_pixel = 0, hud_is_money = 0, busy = 0, done = 0.
  - Display digits all 0 (shows "0" in each field); FSM in IDLE.
- frame_start accepted at cycle T: busy = 1 from T+1. Commit occurs at T+26; done is high during T+26 only; busy = 0 from T+27.
- Pixel latency: DrawX/DrawY at cycle t → rom_addr valid at t+1 → hud_pixel and hud_is_money valid at t+2.
- The pixel pipeline runs every cycle, independent of the FSM state.
- Reset asserted mid-conversion:
  - Next cycle the FSM is in IDLE with busy = 0 and digits cleared.
  - No done pulse is issued.
- lives_in and money_in changing during conversion have no effect; only the LOAD snapshot is used.
- Arithmetic: field offsets use 10-bit unsigned subtraction, guarded by the ≥ comparison so wrap-around never produces a false hit.

## Test plan
- Reset → all outputs 0. Drawing lives-field digit 2 (DrawX = 32, DrawY = 10) yields rom_addr = 2 (glyph "0", row 2).
- lives_in = 42, money_in = 1234, frame_start at T → done at T+26. Lives digits are {blank, 4, 2}; money digits are {1, 2, 3, 4}.
- lives_in = 1023, money_in = 16383 → displayed 999 and 9999.
- Second frame_start at T+5 during conversion → ignored: exactly one done at T+26, with no extra busy cycles.
- lives = 7 committed, DrawX = 32, DrawY = 10 at t:
  - rom_addr = 114 at t+1.
  - hud_pixel = 1 and hud_is_money = 0 at t+2.
  - DrawX = 39 gives hud_pixel = 0.
  - DrawX = 16 (blanked leading digit) gives hud_pixel = 0.
- Reset asserted at T+12 of a conversion → busy = 0 next cycle, digits read "0", and no done pulse follows.
